// File: rtl/video_pkg.sv
// Shared video definitions: scanline dim modes and the default colour width.
package video_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        SL_OFF = 2'd0,
        SL_25  = 2'd1,
        SL_50  = 2'd2,
        SL_75  = 2'd3
    } sl_mode_e;

endpackage

// File: rtl/scanline_dim.sv
// Single-channel scanline attenuator; combinational, passes colour through when not enabled.
module scanline_dim
    import video_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic [DW-1:0] color,
    input  logic          en,
    input  sl_mode_e      mode,
    output logic [DW-1:0] color_c
);

    // Every mode is a pure right-shift or a subtract of a smaller value, so no overflow.
    always_comb begin
        color_c = color;
        if (en) begin
            case (mode)
                SL_OFF:  color_c = color;
                SL_25:   color_c = color - (color >> 2);
                SL_50:   color_c = color >> 1;
                SL_75:   color_c = color >> 2;
                default: color_c = color;
            endcase
        end
    end

endmodule

// File: rtl/scanline_fx.sv
// CRT scanline emulation after the line doubler: dims odd lines, one-pixel pipeline.
// Optional horizontal blend before the dim stage when SCANLINE_FX_HBLEND_EN is defined.
module scanline_fx
    import video_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          ce_pix,
    input  logic [1:0]    scanlines,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hb_in,
    input  logic          vb_in,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    output logic          ce_pix_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          hb_out,
    output logic          vb_out,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out
);

    logic          hs_d;
    logic          vs_d;
    logic          line_odd;
    sl_mode_e      mode_r;

    logic          hs_rise_c;
    logic          vs_rise_c;
    logic          blank_c;
    logic          dim_en_c;
    logic [DW-1:0] src_r_c;
    logic [DW-1:0] src_g_c;
    logic [DW-1:0] src_b_c;
    logic [DW-1:0] dim_r_c;
    logic [DW-1:0] dim_g_c;
    logic [DW-1:0] dim_b_c;

    assign hs_rise_c = hs_in & ~hs_d;
    assign vs_rise_c = vs_in & ~vs_d;
    assign blank_c   = hb_in | vb_in;
    assign dim_en_c  = line_odd & ~blank_c;

    // Edge detect, line parity and frame-synchronous mode latch run every clk_sys.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            line_odd <= 1'b0;
            mode_r   <= SL_OFF;
        end else begin
            hs_d <= hs_in;
            vs_d <= vs_in;
            if (vs_in) begin
                line_odd <= 1'b0;
            end else if (hs_rise_c) begin
                line_odd <= ~line_odd;
            end
            if (vs_rise_c) begin
                mode_r <= sl_mode_e'(scanlines);
            end
        end
    end

`ifdef SCANLINE_FX_HBLEND_EN
    logic [DW-1:0] prev_r;
    logic [DW-1:0] prev_g;
    logic [DW-1:0] prev_b;
    logic          prev_valid;

    function automatic logic [DW-1:0] blend(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DW:1];
    endfunction

    // Previous active pixel per channel; invalid across blanking so each line starts clean.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prev_r     <= '0;
            prev_g     <= '0;
            prev_b     <= '0;
            prev_valid <= 1'b0;
        end else if (blank_c) begin
            prev_valid <= 1'b0;
        end else if (ce_pix) begin
            prev_r     <= r_in;
            prev_g     <= g_in;
            prev_b     <= b_in;
            prev_valid <= 1'b1;
        end
    end

    assign src_r_c = prev_valid ? blend(r_in, prev_r) : r_in;
    assign src_g_c = prev_valid ? blend(g_in, prev_g) : g_in;
    assign src_b_c = prev_valid ? blend(b_in, prev_b) : b_in;
`else
    assign src_r_c = r_in;
    assign src_g_c = g_in;
    assign src_b_c = b_in;
`endif

    scanline_dim #(.DW(DW)) u_dim_r (
        .color   (src_r_c),
        .en      (dim_en_c),
        .mode    (mode_r),
        .color_c (dim_r_c)
    );

    scanline_dim #(.DW(DW)) u_dim_g (
        .color   (src_g_c),
        .en      (dim_en_c),
        .mode    (mode_r),
        .color_c (dim_g_c)
    );

    scanline_dim #(.DW(DW)) u_dim_b (
        .color   (src_b_c),
        .en      (dim_en_c),
        .mode    (mode_r),
        .color_c (dim_b_c)
    );

    // Output pipeline: one pixel of latency for colour, sync and blank alike.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ce_pix_out <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            hb_out     <= 1'b0;
            vb_out     <= 1'b0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
        end else begin
            ce_pix_out <= ce_pix;
            if (ce_pix) begin
                hs_out <= hs_in;
                vs_out <= vs_in;
                hb_out <= hb_in;
                vb_out <= vb_in;
                r_out  <= blank_c ? '0 : dim_r_c;
                g_out  <= blank_c ? '0 : dim_g_c;
                b_out  <= blank_c ? '0 : dim_b_c;
            end
        end
    end

endmodule

// File: tb/tb_scanline_fx.sv
// Scoreboard bench for scanline_fx; models parity, frame mode latch, dim and optional blend.
module tb_scanline_fx;
    import video_pkg::*;

    localparam int unsigned DW = DW_DEFAULT;
    localparam int unsigned PW = 3 * DW + 4;
`ifdef SCANLINE_FX_HBLEND_EN
    localparam bit BLEND_ON = 1'b1;
`else
    localparam bit BLEND_ON = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce_pix = 1'b0;
    logic [1:0]    scanlines = 2'd0;
    logic          hs_in = 1'b0;
    logic          vs_in = 1'b0;
    logic          hb_in = 1'b0;
    logic          vb_in = 1'b0;
    logic [DW-1:0] r_in = '0;
    logic [DW-1:0] g_in = '0;
    logic [DW-1:0] b_in = '0;
    logic          ce_pix_out;
    logic          hs_out;
    logic          vs_out;
    logic          hb_out;
    logic          vb_out;
    logic [DW-1:0] r_out;
    logic [DW-1:0] g_out;
    logic [DW-1:0] b_out;

    always #5 clk_sys = ~clk_sys;

    scanline_fx #(.DW(DW)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .ce_pix     (ce_pix),
        .scanlines  (scanlines),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hb_in      (hb_in),
        .vb_in      (vb_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .ce_pix_out (ce_pix_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .hb_out     (hb_out),
        .vb_out     (vb_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_exp = '0;
    logic [PW-1:0] out_vec;

    assign out_vec = {hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out};

    // Reference model state
    logic          m_hs_d = 1'b0;
    logic          m_vs_d = 1'b0;
    logic          m_odd  = 1'b0;
    logic [1:0]    m_mode = 2'd0;
    logic          m_pv   = 1'b0;
    logic [DW-1:0] m_prev_r = '0;
    logic [DW-1:0] m_prev_g = '0;
    logic [DW-1:0] m_prev_b = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Mode 1 written as ceil(3c/4), which equals c - floor(c/4).
    function automatic logic [DW-1:0] m_dim(input logic [DW-1:0] c, input logic [1:0] m);
        int unsigned v;
        v = 32'(c);
        case (m)
            2'd1:    return DW'((3 * v + 3) / 4);
            2'd2:    return DW'(v / 2);
            2'd3:    return DW'(v / 4);
            default: return c;
        endcase
    endfunction

    function automatic logic [DW-1:0] m_chan(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                             input bit blank);
        logic [DW-1:0] src;
        int unsigned   s;
        s   = (32'(c) + 32'(p)) / 2;
        src = (BLEND_ON && m_pv) ? DW'(s) : c;
        if (blank) return '0;
        if (m_odd) return m_dim(src, m_mode);
        return src;
    endfunction

    // One clk_sys of stimulus; pushes the expected output for ce_pix cycles, then steps the model.
    task automatic cyc(input bit ce, input bit hs, input bit vs, input bit hb, input bit vb,
                       input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
        bit blank;
        @(negedge clk_sys);
        ce_pix = ce; hs_in = hs; vs_in = vs; hb_in = hb; vb_in = vb;
        r_in = r; g_in = g; b_in = b;
        blank = hb | vb;
        if (ce) begin
            exp_q.push_back({hs, vs, hb, vb, m_chan(r, m_prev_r, blank),
                             m_chan(g, m_prev_g, blank), m_chan(b, m_prev_b, blank)});
        end
        if (blank) begin
            m_pv = 1'b0;
        end else if (ce) begin
            m_pv = 1'b1; m_prev_r = r; m_prev_g = g; m_prev_b = b;
        end
        if (vs) m_odd = 1'b0;
        else if (hs && !m_hs_d) m_odd = !m_odd;
        if (vs && !m_vs_d) m_mode = scanlines;
        m_hs_d = hs;
        m_vs_d = vs;
    endtask

    task automatic pix(input bit hs, input bit vs, input bit hb, input bit vb,
                       input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
        cyc(1'b1, hs, vs, hb, vb, r, g, b);
        cyc(1'b0, hs, vs, hb, vb, r, g, b);
    endtask

    task automatic hblank();
        pix(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        pix(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        pix(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        pix(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic line(input int n, input logic [DW-1:0] c, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                pix(1'b0, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom), DW'($urandom));
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end else begin
                pix(1'b0, 1'b0, 1'b0, 1'b0, c, c, c);
            end
        end
        hblank();
    endtask

    task automatic vsync(input logic [1:0] scan);
        scanlines = scan;
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0);
        pix(1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    endtask

    task automatic do_reset(input logic [1:0] scan_after);
        @(negedge clk_sys);
        rst_n = 1'b0;
        #1 chk("rst_async", {ce_pix_out, out_vec}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            ce_pix = 1'($urandom); hs_in = 1'($urandom); vs_in = 1'($urandom);
            hb_in = 1'($urandom); vb_in = 1'($urandom);
            r_in = DW'($urandom); g_in = DW'($urandom); b_in = DW'($urandom);
            scanlines = 2'($urandom);
        end
        #1 chk("rst_hold", {ce_pix_out, out_vec}, '0);
        exp_q.delete();
        last_exp = '0;
        m_hs_d = 1'b0; m_vs_d = 1'b0; m_odd = 1'b0; m_mode = 2'd0; m_pv = 1'b0;
        m_prev_r = '0; m_prev_g = '0; m_prev_b = '0;
        @(negedge clk_sys);
        ce_pix = 1'b0; hs_in = 1'b0; vs_in = 1'b0; hb_in = 1'b0; vb_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        scanlines = scan_after;
        rst_n = 1'b1;
    endtask

    // Pop on every ce_pix_out; otherwise the outputs must hold the last delivered pixel.
    always @(posedge clk_sys) begin
        #1;
        if (rst_n) begin
            if (ce_pix_out) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ce_out", 64'(ce_pix_out), 64'd0);
                end else begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    chk("pixel", 64'(out_vec), 64'(e));
                    last_exp = e;
                end
            end else begin
                chk("hold", 64'(out_vec), 64'(last_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with arbitrary inputs, released with scanlines=2 but no vsync yet.
        do_reset(2'd2);
        line(4, 8'hFF, 1'b0);
        line(4, 8'hFF, 1'b0);

        // Mode latch: 4 lines at mode 2, then a mid-frame change to 3 is ignored.
        vsync(2'd2);
        for (int l = 0; l < 4; l++) line(3, 8'hFF, 1'b0);
        scanlines = 2'd3;
        line(3, 8'hFF, 1'b0);
        line(3, 8'hFF, 1'b0);
        vsync(2'd3);
        line(3, 8'hFF, 1'b0);
        line(3, 8'hFF, 1'b0);

        // Mode sweep on odd lines, including the small-value boundary.
        for (int m = 0; m < 4; m++) begin
            vsync(2'(m));
            line(2, 8'hFF, 1'b0);
            pix(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
            pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03, 8'h03);
            pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 8'h7F);
            hblank();
        end

        // Simultaneous hs/vs rise from even parity: next line stays undimmed.
        vsync(2'd2);
        line(2, 8'hFF, 1'b0);
        line(2, 8'hFF, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
        pix(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
        pix(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        line(3, 8'hFF, 1'b0);
        line(3, 8'hFF, 1'b0);

        // Blend pattern, then an hblank and a first pixel that must pass unblended.
        vsync(2'd2);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        hblank();
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80);
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h20, 8'h10);
        hblank();

        // ce_pix held low while hsync toggles: outputs freeze, parity keeps tracking.
        line(2, 8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        line(3, 8'hC3, 1'b0);
        line(3, 8'hC3, 1'b0);

        // Random frames with random modes and irregular ce_pix gaps.
        for (int f = 0; f < 3; f++) begin
            vsync(2'($urandom));
            for (int l = 0; l < 4; l++) line(6, '0, 1'b1);
        end

        // Reset asserted mid-line clears outputs immediately.
        pix(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hEE, 8'hDD);
        do_reset(2'd1);
        line(3, 8'h55, 1'b0);
        line(3, 8'h55, 1'b0);

        repeat (4) @(negedge clk_sys);
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scanline_fx.md
# scanline_fx

Post-processing stage placed directly downstream of the line doubler. It takes the doubled RGB stream with its sync and blank signals, and darkens every odd output line by a selectable amount to emulate CRT scanlines. Sync and blank signals pass through with the same pipeline delay as colour, so downstream video output logic sees aligned timing. Mode changes take effect only at frame boundaries, so a frame never mixes intensities.

## Interface
- DW, 8, colour channel width in bits.
- clk_sys  in  1  pixel-domain system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce_pix  in  1  pixel clock enable from the doubler.
- scanlines  in  2  requested mode: 0 off, 1 = 25% dim, 2 = 50% dim, 3 = 75% dim.
- hs_in, vs_in, hb_in, vb_in  in  1 each  doubled sync and blank, active-high.
- r_in, g_in, b_in  in  DW each  doubled colour.
- ce_pix_out  out  1  ce_pix delayed one clk_sys; marks the cycle on which new output data is valid.
- hs_out, vs_out, hb_out, vb_out  out  1 each  sync and blank delayed one pixel.
- r_out, g_out, b_out  out  DW each  processed colour.

## Operation
- Edge detection runs every clk_sys, not gated by ce_pix. hs_d and vs_d are one-cycle delayed copies of hs_in and vs_in.
- Line parity (line_odd):
  - toggles on each hs_in rising edge;
  - is forced to 0 while vs_in is high;
  - vs_in high wins over a simultaneous hs_in edge.
  - The first line after vsync is therefore even (undimmed).
- Mode register (mode_r) loads `scanlines` on the vs_in rising edge only. A mid-frame change is ignored until the next vsync.
- On a ce_pix cycle, the output registers load:
  - syncs and blanks are copied through;
  - colour is forced to 0 if hb_in or vb_in is high;
  - otherwise colour = dim(c) if line_odd and mode_r ≠ 0, else c.
- Dim arithmetic, computed per channel at DW bits, cannot overflow:
  - mode 1: c − (c>>2)
  - mode 2: c>>1
  - mode 3: c>>2
- Examples at DW=8:
  - 0xFF gives 0xC0, 0x7F, 0x3F for modes 1, 2, 3.
  - 0x03 gives 0x03, 0x01, 0x00.
- On non-ce cycles the outputs hold their values.

## Timing
- Latency: one ce_pix for all outputs. Data is visible the clk_sys after the ce_pix cycle, coincident with ce_pix_out.
- line_odd and mode_r update the clk_sys after the triggering edge. A pixel sampled on that same cycle uses the old value, which is acceptable because it is blanked.
- Reset (asynchronous, active-low):
  - every output is 0, including ce_pix_out;
  - line_odd = 0, mode_r = 0, hs_d = vs_d = 0;
  - the optional blend state is 0.
- A reset asserted mid-line clears outputs immediately.
- After release, the first frame is undimmed until the next vs_in rising edge.
- ce_pix held low: outputs freeze, but parity and mode tracking continue.

## Configuration
- SCANLINE_FX_HBLEND_EN defined: colour entering the dim stage is the horizontal blend (c + prev)>>1.
  - The sum is computed at DW+1 bits and truncated.
  - prev is a per-channel register loaded with the input colour on each active ce_pix.
  - A prev_valid flag is cleared while hb_in or vb_in is high and set after the first active pixel.
  - The first active pixel of each line is passed unblended.
- SCANLINE_FX_HBLEND_EN undefined: the blend logic and its registers are absent, and colour goes straight to the dim stage.
- Latency is unchanged in both builds.

## Structure
- Shared package video_pkg holds:
  - the mode enum SL_OFF, SL_25, SL_50, SL_75 (2-bit);
  - the default colour width constant.
- Sub-module scanline_dim: a single-channel DW-bit attenuator taking colour, the enable (line_odd and not blank) and the mode. It is instantiated three times.
- The top level holds the edge detectors, parity, mode latch, the pipeline registers and, when compiled in, the blend registers.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs → all outputs 0. Release with scanlines=2 and no vsync yet → RGB 0xFF passes undimmed as 0xFF.
- Mode latch: scanlines=2, pulse vs_in, drive constant RGB 0xFF for 4 lines → lines 0 and 2 give 0xFF, lines 1 and 3 give 0x7F. Changing to 3 mid-frame has no effect until the next vs_in.
- Mode sweep: on odd lines, input 0xFF gives 0xFF, 0xC0, 0x7F, 0x3F for modes 0 to 3; input 0x03 gives 0x03, 0x03, 0x01, 0x00.
- Blank and latency: ce_pix every 2nd clk, hb_in high for 3 pixels → RGB 0 during blank, and hb_out follows hb_in exactly one ce_pix later, aligned with ce_pix_out.
- Simultaneous hs/vs: hs_in and vs_in rise on the same clk → line_odd ends 0, and the next line is undimmed.
- HBLEND build: active pixels 0x00, 0xFF, 0xFF on line 0 → outputs 0x00, 0x7F, 0xFF. After hblank, the first pixel 0x80 outputs 0x80 (unblended).
